// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter that serialises requester commands onto one register port.
// Optional strict priority for requester 0 when REG_PORT_ARB_PRIO0_EN is defined.
module reg_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ADDR_WIDTH-1:0]            set_addr,
    output logic [DATA_WIDTH-1:0]            set_data,
    output logic                             set_stb,
    output logic [ADDR_WIDTH-1:0]            get_addr,
    output logic                             get_stb,
    input  logic [DATA_WIDTH-1:0]            get_data,
    output logic                             busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       idx_q, idx_d;
    logic                   we_q, we_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  set_addr_q, set_addr_d;
    logic [DATA_WIDTH-1:0]  set_data_q, set_data_d;
    logic [ADDR_WIDTH-1:0]  get_addr_q, get_addr_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   set_stb_q, set_stb_d;
    logic                   get_stb_q, get_stb_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Rotate the request vector so bit 0 is the requester at rr_ptr, then take
    // the lowest set bit as the offset of the winner.
    logic [2*NUM_REQ-1:0]   rot_wide;
    logic                   grant_any;
    logic                   grant_prio;
    logic [PTR_W:0]         grant_off;
    logic [PTR_W:0]         grant_sum;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W:0]         ptr_inc;

    always_comb begin
        rot_wide   = {req_valid, req_valid} >> rr_ptr_q;
        grant_any  = 1'b0;
        grant_prio = 1'b0;
        grant_off  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_wide[k]) begin
                grant_any = 1'b1;
                grant_off = (PTR_W+1)'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + grant_off;
        if (grant_sum >= (PTR_W+1)'(NUM_REQ)) begin
            grant_sum = grant_sum - (PTR_W+1)'(NUM_REQ);
        end
        grant_idx = grant_sum[PTR_W-1:0];
`ifdef REG_PORT_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_prio = 1'b1;
            grant_idx  = '0;
        end
`endif
        ptr_inc = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (ptr_inc == (PTR_W+1)'(NUM_REQ)) begin
            ptr_inc = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == IDLE) && grant_any && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        set_addr_d  = set_addr_q;
        set_data_d  = set_data_q;
        get_addr_d  = get_addr_q;
        rsp_data_d  = rsp_data_q;
        set_stb_d   = 1'b0;
        get_stb_d   = 1'b0;
        rsp_valid_d = '0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    idx_d = grant_idx;
                    we_d  = req_we[grant_idx];
                    // Port registers load at acceptance so the strobe and its
                    // address/data appear together in the ISSUE cycle.
                    if (req_we[grant_idx]) begin
                        set_addr_d = addr_arr[grant_idx];
                        set_data_d = wdata_arr[grant_idx];
                        set_stb_d  = 1'b1;
                    end else begin
                        get_addr_d = addr_arr[grant_idx];
                        get_stb_d  = 1'b1;
                    end
                    if (!grant_prio) begin
                        rr_ptr_d = ptr_inc[PTR_W-1:0];
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    rsp_data_d  = '0;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    state_d     = RESP;
                end else if (RD_LATENCY == 0) begin
                    rsp_data_d  = get_data;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    state_d     = RESP;
                end else begin
                    cnt_d   = 4'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'(RD_LATENCY)) begin
                    rsp_data_d  = get_data;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            set_addr_q  <= '0;
            set_data_q  <= '0;
            get_addr_q  <= '0;
            rsp_data_q  <= '0;
            set_stb_q   <= 1'b0;
            get_stb_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            set_addr_q  <= set_addr_d;
            set_data_q  <= set_data_d;
            get_addr_q  <= get_addr_d;
            rsp_data_q  <= rsp_data_d;
            set_stb_q   <= set_stb_d;
            get_stb_q   <= get_stb_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign set_addr  = set_addr_q;
    assign set_data  = set_data_q;
    assign set_stb   = set_stb_q;
    assign get_addr  = get_addr_q;
    assign get_stb   = get_stb_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: queued requester commands, a register
// file responder, a transaction-level model and a decoupled response monitor.
module tb_reg_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 3;
`ifdef REG_PORT_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_we = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     set_addr;
    logic [DW-1:0]     set_data;
    logic              set_stb;
    logic [AW-1:0]     get_addr;
    logic              get_stb;
    logic [DW-1:0]     get_data = '0;
    logic              busy;

    reg_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_stb(get_stb), .get_data(get_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } cmd_t;

    typedef struct {
        logic [N-1:0]  onehot;
        logic [DW-1:0] data;
    } rsp_t;

    cmd_t          cmdq [N][$];
    cmd_t          pres [N];
    rsp_t          sbq [$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] rf_mem  [logic [AW-1:0]];

    int total = 0;
    int bad   = 0;
    int grant_cnt [N] = '{default: 0};
    int seen_cnt  [N] = '{default: 0};
    int gap_cnt   [N] = '{default: 0};
    bit active    [N] = '{default: 1'b0};

    // Transaction-level model state: phase counts cycles since acceptance.
    int            ph = 0;
    int            done_ph = 0;
    int            ptr = 0;
    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    bit            rst_seen = 1'b0;
    bit            end_check = 1'b0;
    bit            end_done = 1'b0;
    bit            drain_fail = 1'b0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [DW-1:0] rf_rd(input logic [AW-1:0] a);
        if (rf_mem.exists(a)) return rf_mem[a];
        return dflt(a);
    endfunction

    // First valid requester at or after p, wrapping; requester 0 overrides when prioritised.
    function automatic int pick(input logic [N-1:0] v, input int p);
        if (PRIO0 && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file responder: data valid exactly L cycles after the get_stb cycle.
    bit            rd_pend = 1'b0;
    int            rd_cnt = 0;
    logic [AW-1:0] rd_addr = '0;
    always @(negedge clk) begin
        if (set_stb) rf_mem[set_addr] = set_data;
        if (get_stb) begin
            rd_pend = 1'b1;
            rd_cnt  = 0;
            rd_addr = get_addr;
        end else if (rd_pend) begin
            rd_cnt++;
        end
        if (rd_pend && rd_cnt == L) begin
            get_data = rf_rd(rd_addr);
            rd_pend  = 1'b0;
        end else begin
            get_data = $urandom;
        end
    end

    // Model: grant decisions, strobe timing and scoreboard pushes.
    always @(negedge clk) begin
        int           w;
        logic [N-1:0] exp_ready;
        rsp_t         r;
        if (rst) begin
            ph       = 0;
            ptr      = 0;
            sbq.delete();
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                chk("rst_busy", busy, 0);
                chk("rst_set_addr", set_addr, 0);
                chk("rst_set_data", set_data, 0);
                chk("rst_get_addr", get_addr, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_strobes", {set_stb, get_stb}, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                rst_seen = 1'b0;
            end
            w = -1;
            exp_ready = '0;
            if (ph == 0) begin
                w = pick(req_valid, ptr);
                if (w >= 0) exp_ready = N'(1) << w;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, ph != 0);
            chk("set_stb", set_stb, ph == 1 && cur_we);
            chk("get_stb", get_stb, ph == 1 && !cur_we);
            chk("rsp_timing", rsp_valid != 0, ph != 0 && ph == done_ph);
            if (ph == 1 && cur_we) begin
                chk("set_addr", set_addr, cur_addr);
                chk("set_data", set_data, cur_wdata);
            end
            if (ph == 1 && !cur_we) chk("get_addr", get_addr, cur_addr);

            if (ph == 0) begin
                if (w >= 0) begin
                    cur_we    = pres[w].we;
                    cur_addr  = pres[w].addr;
                    cur_wdata = pres[w].wdata;
                    r.onehot  = N'(1) << w;
                    r.data    = cur_we ? '0 : ref_rd(cur_addr);
                    sbq.push_back(r);
                    if (cur_we) ref_mem[cur_addr] = cur_wdata;
                    done_ph = cur_we ? 2 : 2 + L;
                    ph = 1;
                    if (!(PRIO0 && w == 0)) ptr = (w + 1) % N;
                    grant_cnt[w]++;
                end
            end else if (ph == done_ph) begin
                ph = 0;
            end else begin
                ph++;
            end

            if (end_check && !end_done) begin
                chk("sb_empty", sbq.size(), 0);
                chk("drain_timeout", drain_fail, 0);
                end_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        rsp_t r;
        if (!rst && rsp_valid != 0) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                r = sbq.pop_front();
                $display("rsp: valid=%b data=%h expected valid=%b data=%h", rsp_valid, rsp_data, r.onehot, r.data);
                chk("rsp_onehot", rsp_valid, r.onehot);
                chk("rsp_data", rsp_data, r.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (active[i] && grant_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = grant_cnt[i];
                active[i]   = 1'b0;
            end
            if (!active[i] && cmdq[i].size() > 0) begin
                if (gap_cnt[i] < cmdq[i][0].gap) begin
                    gap_cnt[i]++;
                end else begin
                    pres[i]    = cmdq[i].pop_front();
                    gap_cnt[i] = 0;
                    active[i]  = 1'b1;
                end
            end
            req_valid[i] = active[i];
            if (active[i]) begin
                req_we[i]               = pres[i].we;
                req_addr[i*AW +: AW]    = pres[i].addr;
                req_wdata[i*DW +: DW]   = pres[i].wdata;
            end else begin
                req_we[i]               = 1'($urandom);
                req_addr[i*AW +: AW]    = $urandom;
                req_wdata[i*DW +: DW]   = $urandom;
            end
        end
    endtask

    function automatic bit quiet();
        if (ph != 0) return 1'b0;
        for (int i = 0; i < N; i++) begin
            if (active[i] || cmdq[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        step();
        while (!quiet() && n < budget) begin
            step();
            n++;
        end
        if (!quiet()) drain_fail = 1'b1;
    endtask

    task automatic push(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.gap = gap;
        cmdq[i].push_back(c);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        ref_mem[32'h24] = 32'h1234_5678;
        rf_mem[32'h24]  = 32'h1234_5678;
        repeat (3) step();
        rst = 1'b0;
        step();

        push(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        drain(100);
        push(1, 1'b0, 32'h24, 32'h0, 0);
        drain(100);

        pulse_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
            push(i, 1'b1, 32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i), 0);
        end
        drain(200);

        push(3, 1'b1, 32'h30, 32'h3333_3333, 0);
        drain(100);
        push(0, 1'b0, 32'h30, 32'h0, 0);
        drain(100);

        push(0, 1'b1, 32'h40, 32'hCAFE_F00D, 0);
        push(0, 1'b0, 32'h40, 32'h0, 0);
        drain(100);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                push(i, 1'($urandom), 32'($urandom_range(0, 7)) << 2, $urandom, int'($urandom_range(0, 4)));
            end
        end
        drain(5000);

        push(1, 1'b0, 32'h40, 32'h0, 0);
        n = 0;
        step();
        while (ph != 3 && n < 50) begin
            step();
            n++;
        end
        if (ph != 3) drain_fail = 1'b1;
        pulse_reset();
        drain(100);
        push(1, 1'b0, 32'h24, 32'h0, 0);
        drain(100);

        end_check = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
